// File: rtl/insn_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the
// valid/ready instruction stream toward decode.
interface insn_fetch_if #(
   parameter int PC_WIDTH = 8
);
   logic                mem_req;
   logic [PC_WIDTH-1:0] mem_addr;
   logic                mem_ack;
   logic [7:0]          mem_rdata;
   logic [7:0]          insn;
   logic [PC_WIDTH-1:0] insn_pc;
   logic                insn_valid;
   logic                insn_ready;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata,
      output insn,
      output insn_pc,
      output insn_valid,
      input  insn_ready
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      input  mem_rdata,
      input  insn,
      input  insn_pc,
      input  insn_valid,
      output insn_ready
   );
endinterface

// File: rtl/insn_fetch.sv
// Instruction fetch stage: PC, single-outstanding memory reads,
// 2-entry instruction FIFO and redirect/drain handling.
module insn_fetch #(
   parameter int                  PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fetch_en,
   input  logic                redirect_en,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   insn_fetch_if.master        bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DRAIN
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] w_pc_nxt;
   logic [PC_WIDTH-1:0] r_pend;
   logic [PC_WIDTH-1:0] w_pend_nxt;

   logic [7:0]          r_fd [2];
   logic [PC_WIDTH-1:0] r_fa [2];
   logic                r_rd;
   logic [1:0]          r_count;

   logic                w_valid;
   logic                w_pop;
   logic                w_push;
   logic                w_wr;
   logic [1:0]          w_left;

   assign w_valid = (r_count != 2'd0);
   assign w_pop   = w_valid & bus.insn_ready & ~redirect_en;
   assign w_push  = (r_state == S_REQ) & bus.mem_ack
                  & ~redirect_en;
   assign w_wr    = r_rd ^ r_count[0];
   assign w_left  = r_count - {1'b0, w_pop};

   assign bus.mem_req    = (r_state != S_IDLE);
   assign bus.mem_addr   = r_pc;
   assign bus.insn       = r_fd[r_rd];
   assign bus.insn_pc    = r_fa[r_rd];
   assign bus.insn_valid = w_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_pend  <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   // r_pend holds a redirect target while a killed request drains,
   // so mem_addr stays put until the old read acks.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_pend_nxt  = r_pend;
      unique case (r_state)
         S_IDLE: begin
            if (redirect_en)
               w_pc_nxt = redirect_pc;
            if (fetch_en && (redirect_en || w_left < 2'd2))
               w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (bus.mem_ack) begin
               if (redirect_en) begin
                  w_pc_nxt    = redirect_pc;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_pc_nxt = r_pc + 1'b1;
                  if (!(fetch_en && w_left == 2'd0))
                     w_state_nxt = S_IDLE;
               end
            end else if (redirect_en) begin
               w_pend_nxt  = redirect_pc;
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (bus.mem_ack) begin
               w_pc_nxt    = redirect_en ? redirect_pc : r_pend;
               w_state_nxt = S_IDLE;
            end else if (redirect_en) begin
               w_pend_nxt = redirect_pc;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd    <= 1'b0;
         r_count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_fd[i] <= '0;
            r_fa[i] <= '0;
         end
      end else if (redirect_en) begin
         r_rd    <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) begin
            r_fd[w_wr] <= bus.mem_rdata;
            r_fa[w_wr] <= r_pc;
         end
         if (w_pop)
            r_rd <= ~r_rd;
         r_count <= r_count + {1'b0, w_push}
                  - {1'b0, w_pop};
      end
   end

endmodule
